// File: rtl/surf_wb_pkg.sv
// Shared definitions for the Wishbone classic initiator.
//   wb_state_e  : controller states (IDLE, BUS, GAP, RESP)
//   wb_status_e : completion status returned on rsp_status_o
//   sat_inc8    : 8-bit saturating increment used by the error counter
package surf_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_GAP  = 2'd2,
    ST_RESP = 2'd3
  } wb_state_e;

  typedef enum logic [1:0] {
    STS_OK            = 2'b00,
    STS_ERR           = 2'b01,
    STS_RTY_EXHAUSTED = 2'b10,
    STS_TIMEOUT       = 2'b11
  } wb_status_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/surf_wb_initiator_if.sv
// Command / response / Wishbone bundle for surf_wb_initiator.
//   cmd_*  : command channel (valid/ready) into the initiator
//   rsp_*  : response channel (valid/ready) out of the initiator
//   wb_*   : Wishbone classic initiator-side signals
// Modports:
//   master : the initiator block itself (drives cmd_ready, rsp_*, wb_*_o)
//   slave  : the environment (command source, response sink, Wishbone target)
interface surf_wb_initiator_if #(
  parameter int WB_ADR_BITS = 11
) ();

  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic                   cmd_we_i;
  logic [WB_ADR_BITS-1:0] cmd_adr_i;
  logic [31:0]            cmd_dat_i;
  logic [3:0]             cmd_sel_i;

  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [31:0]            rsp_dat_o;
  logic [1:0]             rsp_status_o;

  logic                   wb_cyc_o;
  logic                   wb_stb_o;
  logic                   wb_we_o;
  logic [WB_ADR_BITS-1:0] wb_adr_o;
  logic [31:0]            wb_dat_o;
  logic [3:0]             wb_sel_o;
  logic [31:0]            wb_dat_i;
  logic                   wb_ack_i;
  logic                   wb_err_i;
  logic                   wb_rty_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  rsp_ready_i,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o,
    output rsp_ready_i,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

endinterface

// File: rtl/surf_wb_initiator.sv
// Single-transfer Wishbone classic initiator.
// Takes one command at a time, runs it on the bus with retry and timeout
// handling, and returns one response with a 2-bit status.
// Ports:
//   wb_clk_i     : clock, all logic on the rising edge
//   wb_rst_n_i   : asynchronous active-low reset
//   bus          : surf_wb_initiator_if.master (cmd, rsp and Wishbone signals)
//   err_count_o  : saturating count of non-OK completions
// Parameters:
//   WB_ADR_BITS    : Wishbone address width
//   TIMEOUT_CYCLES : max cycles of one bus attempt (1..255)
//   MAX_RETRY      : re-issues allowed after rty (0..15)
module surf_wb_initiator
  import surf_wb_pkg::*;
#(
  parameter int WB_ADR_BITS    = 11,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  surf_wb_initiator_if.master bus,
  output logic [7:0]          err_count_o
);

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

  wb_state_e              state_q;
  logic                   cmd_ready_q;
  logic                   cyc_q;
  logic                   we_q;
  logic [WB_ADR_BITS-1:0] adr_q;
  logic [31:0]            dat_q;
  logic [3:0]             sel_q;
  logic                   rsp_valid_q;
  logic [31:0]            rsp_dat_q;
  wb_status_e             rsp_status_q;
  logic [7:0]             err_cnt_q;
  logic [7:0]             tmo_cnt_q;
  logic [3:0]             retry_q;

  // Termination decode for the current BUS cycle; ack > err > rty > timeout.
  // Everything here is gated by ST_BUS so stray target strobes are ignored
  // in the other states.
  logic       done;
  wb_status_e done_sts;
  logic [31:0] done_dat;
  logic       retry_go;

  always_comb begin
    done     = 1'b0;
    done_sts = STS_OK;
    done_dat = '0;
    retry_go = 1'b0;
    if (state_q == ST_BUS) begin
      if (bus.wb_ack_i) begin
        done     = 1'b1;
        done_sts = STS_OK;
        done_dat = we_q ? 32'd0 : bus.wb_dat_i;
      end else if (bus.wb_err_i) begin
        done     = 1'b1;
        done_sts = STS_ERR;
      end else if (bus.wb_rty_i) begin
        if (retry_q == RETRY_LIM) begin
          done     = 1'b1;
          done_sts = STS_RTY_EXHAUSTED;
        end else begin
          retry_go = 1'b1;
        end
      end else if (tmo_cnt_q == TMO_LAST) begin
        // tmo_cnt_q counts completed BUS cycles of this attempt, so this
        // fires on the TIMEOUT_CYCLES-th cycle with cyc high.
        done     = 1'b1;
        done_sts = STS_TIMEOUT;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= STS_OK;
      err_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      retry_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Ready comes up on the first edge after reset release and
          // stays up until a command is taken.
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            we_q        <= bus.cmd_we_i;
            adr_q       <= bus.cmd_adr_i;
            dat_q       <= bus.cmd_dat_i;
            sel_q       <= bus.cmd_sel_i;
            cyc_q       <= 1'b1;
            tmo_cnt_q   <= '0;
            retry_q     <= '0;
            state_q     <= ST_BUS;
          end
        end

        ST_BUS: begin
          if (done) begin
            cyc_q        <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_dat_q    <= done_dat;
            rsp_status_q <= done_sts;
            if (done_sts != STS_OK) err_cnt_q <= sat_inc8(err_cnt_q);
            state_q      <= ST_RESP;
          end else if (retry_go) begin
            cyc_q   <= 1'b0;
            retry_q <= retry_q + 4'd1;
            state_q <= ST_GAP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end

        // One idle cycle between attempts; address/data regs are untouched
        // so the re-issue is identical.
        ST_GAP: begin
          cyc_q     <= 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= ST_BUS;
        end

        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o  = cmd_ready_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_status_o = rsp_status_q;
  assign bus.wb_cyc_o     = cyc_q;
  assign bus.wb_stb_o     = cyc_q;
  assign bus.wb_we_o      = we_q;
  assign bus.wb_adr_o     = adr_q;
  assign bus.wb_dat_o     = dat_q;
  assign bus.wb_sel_o     = sel_q;
  assign err_count_o      = err_cnt_q;

endmodule
